// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo interleaver scheduler: PB size codes, block
// lengths, sequencer states and datapath mode encoding.
package turbo_pkg;

  localparam logic [1:0] PB16    = 2'b00;
  localparam logic [1:0] PB136   = 2'b01;
  localparam logic [1:0] PB520   = 2'b10;
  localparam logic [1:0] PB_RSVD = 2'b11;

  localparam int PB_LEN_16  = 64;
  localparam int PB_LEN_136 = 544;
  localparam int PB_LEN_520 = 2080;

  localparam logic MODE_ITL  = 1'b0;
  localparam logic MODE_DITL = 1'b1;

  typedef enum logic [2:0] {IDLE, LOAD, START, DRAIN, DONE} state_t;

  // Block length in dibits; the reserved code never reaches here because it is never granted.
  function automatic logic [11:0] pb_len(input logic [1:0] sz);
    case (sz)
      PB16:    return 12'(PB_LEN_16);
      PB136:   return 12'(PB_LEN_136);
      default: return 12'(PB_LEN_520);
    endcase
  endfunction

endpackage

// File: rtl/turbo_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = TX, bit 1 = RX. The pointer names the side
// that wins a tie and moves to the other side of the finishing owner on update.
module turbo_rr_arb2 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] gnt
);

  logic ptr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~owner;
    end
  end

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/turbo_itl_sched.sv
// Shares one turbo interleaver datapath between the TX encoder and RX decoder,
// sequencing one PB job at a time: load dibits, pulse start, count output beats.
module turbo_itl_sched
  import turbo_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_req,
  input  logic [1:0] tx_pb_size,
  input  logic [1:0] tx_din,
  input  logic       tx_din_vld,
  output logic       tx_gnt,
  output logic       tx_done,
  input  logic       rx_req,
  input  logic [1:0] rx_pb_size,
  input  logic [1:0] rx_din,
  input  logic       rx_din_vld,
  output logic       rx_gnt,
  output logic       rx_done,
  output logic [1:0] itl_pb_size,
  output logic [1:0] itl_din,
  output logic       itl_din_vld,
  output logic       itl_start,
  output logic       itl_mode,
  input  logic       itl_dout_vld,
  output logic       busy,
  output logic       err_rsvd,
  output logic       err_tmo
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [WD_W-1:0]  wdog;

  logic [1:0] elig;
  logic [1:0] gnt_sel;
  logic [1:0] sel_size;
  logic       own_din_vld;
  logic [1:0] own_din;
  logic       abort;
  logic       arb_update;

  assign elig = {rx_req && (rx_pb_size != PB_RSVD), tx_req && (tx_pb_size != PB_RSVD)};
  assign sel_size = gnt_sel[1] ? rx_pb_size : tx_pb_size;

  // itl_mode doubles as the owner index: 0 = TX, 1 = RX
  assign own_din_vld = itl_mode ? rx_din_vld : tx_din_vld;
  assign own_din     = itl_mode ? rx_din : tx_din;

  assign abort      = (state == DRAIN) && !itl_dout_vld && (wdog == WD_W'(TIMEOUT - 1));
  assign arb_update = (state == DONE) || abort;
  assign busy       = (state != IDLE);

  turbo_rr_arb2 u_arb (
    .clk    (clk),
    .n_rst  (n_rst),
    .req    (elig),
    .update (arb_update),
    .owner  (itl_mode),
    .gnt    (gnt_sel)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      len_reg     <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wdog        <= '0;
      tx_gnt      <= 1'b0;
      rx_gnt      <= 1'b0;
      tx_done     <= 1'b0;
      rx_done     <= 1'b0;
      itl_pb_size <= 2'b00;
      itl_din     <= 2'b00;
      itl_din_vld <= 1'b0;
      itl_start   <= 1'b0;
      itl_mode    <= MODE_ITL;
      err_rsvd    <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      rx_done     <= 1'b0;
      itl_din_vld <= 1'b0;
      itl_start   <= 1'b0;
      err_tmo     <= 1'b0;
      err_rsvd    <= (tx_req && (tx_pb_size == PB_RSVD)) || (rx_req && (rx_pb_size == PB_RSVD));
      case (state)
        IDLE: begin
          if (|gnt_sel) begin
            itl_mode    <= gnt_sel[1] ? MODE_DITL : MODE_ITL;
            itl_pb_size <= sel_size;
            len_reg     <= CNT_W'(pb_len(sel_size));
            tx_gnt      <= gnt_sel[0];
            rx_gnt      <= gnt_sel[1];
            in_cnt      <= '0;
            out_cnt     <= '0;
            wdog        <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (own_din_vld) begin
            itl_din     <= own_din;
            itl_din_vld <= 1'b1;
            in_cnt      <= in_cnt + CNT_W'(1);
            if (in_cnt == len_reg - CNT_W'(1)) begin
              state <= START;
            end
          end
        end
        START: begin
          itl_start <= 1'b1;
          wdog      <= '0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (itl_dout_vld) begin
            wdog    <= '0;
            out_cnt <= out_cnt + CNT_W'(1);
            if (out_cnt == (len_reg >> 2) - CNT_W'(1)) begin
              tx_done <= ~itl_mode;
              rx_done <= itl_mode;
              state   <= DONE;
            end
          end else if (abort) begin
            err_tmo <= 1'b1;
            tx_gnt  <= 1'b0;
            rx_gnt  <= 1'b0;
            state   <= IDLE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        DONE: begin
          tx_gnt <= 1'b0;
          rx_gnt <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_itl_sched.sv
// Scoreboard bench for turbo_itl_sched: drivers push expected dibits and job outcomes,
// a negedge monitor pops and compares them as the scheduler presents them.
module tb_turbo_itl_sched;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_req = 1'b0, rx_req = 1'b0;
  logic [1:0] tx_pb_size = 2'b00, rx_pb_size = 2'b00;
  logic [1:0] tx_din = 2'b00, rx_din = 2'b00;
  logic       tx_din_vld = 1'b0, rx_din_vld = 1'b0;
  logic       tx_gnt, tx_done, rx_gnt, rx_done;
  logic [1:0] itl_pb_size, itl_din;
  logic       itl_din_vld, itl_start, itl_mode;
  logic       itl_dout_vld = 1'b0;
  logic       busy, err_rsvd, err_tmo;

  turbo_itl_sched #(.TIMEOUT(16), .CNT_W(12)) dut (
    .clk(clk), .n_rst(n_rst),
    .tx_req(tx_req), .tx_pb_size(tx_pb_size), .tx_din(tx_din), .tx_din_vld(tx_din_vld),
    .tx_gnt(tx_gnt), .tx_done(tx_done),
    .rx_req(rx_req), .rx_pb_size(rx_pb_size), .rx_din(rx_din), .rx_din_vld(rx_din_vld),
    .rx_gnt(rx_gnt), .rx_done(rx_done),
    .itl_pb_size(itl_pb_size), .itl_din(itl_din), .itl_din_vld(itl_din_vld),
    .itl_start(itl_start), .itl_mode(itl_mode), .itl_dout_vld(itl_dout_vld),
    .busy(busy), .err_rsvd(err_rsvd), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 = tx_done, 1 = rx_done, 2 = err_tmo
    bit         mode;
    logic [1:0] sz;
    int         len;
  } job_t;

  job_t       exp_job_q[$];
  logic [1:0] exp_din_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0, din_cnt = 0, start_cnt = 0, dout_cnt = 0, job_no = 0;
  int last_din_cyc = 0, last_dout_cyc = 0, start_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!n_rst) begin
      din_cnt = 0; start_cnt = 0; dout_cnt = 0;
    end else begin
      if (itl_din_vld) begin
        if (exp_din_q.size() == 0) chk("din_queue", exp_din_q.size(), 1);
        else chk("din_data", int'(itl_din), int'(exp_din_q.pop_front()));
        din_cnt++;
        last_din_cyc = cyc;
      end
      if (itl_start) begin
        chk("start_latency", cyc - last_din_cyc, 1);
        start_cnt++;
        start_cyc = cyc;
      end
      if (itl_dout_vld) begin
        dout_cnt++;
        last_dout_cyc = cyc;
      end
      if (tx_done || rx_done || err_tmo) begin
        int act_kind;
        job_t j;
        act_kind = err_tmo ? 2 : (rx_done ? 1 : 0);
        chk("single_event", int'(tx_done) + int'(rx_done) + int'(err_tmo), 1);
        if (exp_job_q.size() == 0) begin
          chk("job_queue", exp_job_q.size(), 1);
        end else begin
          j = exp_job_q.pop_front();
          job_no++;
          chk("job_kind", act_kind, j.kind);
          chk("job_mode", int'(itl_mode), int'(j.mode));
          chk("job_pb_size", int'(itl_pb_size), int'(j.sz));
          chk("job_din_count", din_cnt, j.len);
          chk("job_start_count", start_cnt, 1);
          if (j.kind == 2) begin
            chk("tmo_latency", cyc - start_cyc, 16);
            chk("busy_after_tmo", int'(busy), 0);
            chk("gnt_after_tmo", int'({tx_gnt, rx_gnt}), 0);
          end else begin
            chk("done_latency", cyc - last_dout_cyc, 1);
            chk("dout_beats", dout_cnt, j.len / 4);
            chk("gnt_during_done", int'(j.mode ? rx_gnt : tx_gnt), 1);
          end
          $display("JOB %0d side=%s size=%0d dibits=%0d beats=%0d event=%s", job_no,
                   itl_mode ? "RX" : "TX", itl_pb_size, din_cnt, dout_cnt,
                   err_tmo ? "timeout" : "done");
        end
        din_cnt = 0; start_cnt = 0; dout_cnt = 0;
      end
    end
  end

  task automatic set_req(input bit side, input logic r, input logic [1:0] sz);
    if (side) begin rx_req = r; rx_pb_size = sz; end
    else      begin tx_req = r; tx_pb_size = sz; end
  endtask

  task automatic drive_side(input bit side, input logic [1:0] d, input logic v);
    if (side) begin rx_din = d; rx_din_vld = v; end
    else      begin tx_din = d; tx_din_vld = v; end
  endtask

  task automatic wait_gnt(input bit side, output bit ok);
    int n = 0;
    while (!(side ? rx_gnt : tx_gnt) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    ok = side ? rx_gnt : tx_gnt;
    chk(side ? "rx_gnt_wait" : "tx_gnt_wait", int'(ok), 1);
    chk("gnt_exclusive", int'(side ? tx_gnt : rx_gnt), 0);
  endtask

  task automatic feed(input bit side, input int len, input bit gaps, input bit noise);
    int i = 0;
    while (i < len) begin
      logic [1:0] d;
      d = 2'((i ^ (i >> 2)) + int'(side));
      if (gaps && $urandom_range(0, 3) == 0) begin
        drive_side(side, ~d, 1'b0);
      end else begin
        drive_side(side, d, 1'b1);
        exp_din_q.push_back(d);
        i++;
      end
      if (noise) drive_side(~side, 2'($urandom), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    drive_side(side, 2'b00, 1'b0);
    if (noise) drive_side(~side, 2'b00, 1'b0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!itl_start && n < 12) begin
      @(posedge clk); #1; n++;
    end
    chk("start_wait", int'(itl_start), 1);
  endtask

  task automatic drain(input int beats, input bit tmo);
    int n = 0;
    wait_start();
    if (!tmo) begin
      for (int b = 0; b < beats; b++) begin
        itl_dout_vld = 1'b1;
        @(posedge clk); #1;
      end
      itl_dout_vld = 1'b0;
    end
    while (busy && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  task automatic run_job(input bit side, input logic [1:0] sz, input bit gaps, input bit noise,
                         input bit tmo, input bit raise);
    int   len;
    bit   ok;
    job_t j;
    len = (sz == 2'b00) ? 64 : (sz == 2'b01) ? 544 : 2080;
    if (raise) set_req(side, 1'b1, sz);
    wait_gnt(side, ok);
    // Drop the request and scramble the size: neither may affect the running job
    set_req(side, 1'b0, (sz == 2'b00) ? 2'b10 : 2'b00);
    if (ok) begin
      j.kind = tmo ? 2 : int'(side);
      j.mode = side;
      j.sz   = sz;
      j.len  = len;
      exp_job_q.push_back(j);
      feed(side, len, gaps, noise);
      drain(len / 4, tmo);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, int'({tx_gnt, tx_done, rx_gnt, rx_done, itl_pb_size, itl_din, itl_din_vld,
                    itl_start, itl_mode, busy, err_rsvd, err_tmo}), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    #22;
    chk_outs_zero("reset_outputs");
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Tie from reset at PB520: TX first, then RX
    set_req(1'b0, 1'b1, 2'b10);
    set_req(1'b1, 1'b1, 2'b10);
    run_job(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    // Repeat tie after RX served: TX wins again
    set_req(1'b0, 1'b1, 2'b00);
    set_req(1'b1, 1'b1, 2'b00);
    run_job(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // TX alone PB16, then a tie must go to RX
    run_job(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    set_req(1'b0, 1'b1, 2'b00);
    set_req(1'b1, 1'b1, 2'b00);
    run_job(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reserved size on RX: flagged, never granted; TX PB136 still served
    set_req(1'b1, 1'b1, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    chk("err_rsvd_set", int'(err_rsvd), 1);
    chk("rsvd_not_busy", int'(busy), 0);
    run_job(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rsvd_rx_gnt", int'(rx_gnt), 0);
    chk("rsvd_idle", int'(busy), 0);
    chk("err_rsvd_held", int'(err_rsvd), 1);
    set_req(1'b1, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("err_rsvd_clear", int'(err_rsvd), 0);

    // PB136 with din gaps and RX din noise
    run_job(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);

    // Watchdog abort: no output beats after start
    run_job(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-drain, then a fresh job
    set_req(1'b0, 1'b1, 2'b00);
    wait_gnt(1'b0, ok);
    set_req(1'b0, 1'b0, 2'b00);
    if (ok) begin
      feed(1'b0, 64, 1'b0, 1'b0);
      wait_start();
      itl_dout_vld = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      itl_dout_vld = 1'b0;
    end
    chk("busy_before_reset", int'(busy), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_outs_zero("async_reset_outputs");
    exp_din_q.delete();
    exp_job_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    run_job(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("job_queue_empty", exp_job_q.size(), 0);
    chk("din_queue_empty", exp_din_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
